// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine cycle controller.
// Holds the FSM state codes, step/program/motor codes and a small
// saturating-add helper used by the duration lookup.
package wash_pkg;

    // FSM state codes as shown on the display output.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_RUN   = S_RUN,
        ST_GAP   = S_GAP,
        ST_PAUSE = S_PAUSE,
        ST_DONE  = S_DONE,
        ST_FAULT = S_FAULT
    } state_e;

    // Step indices, also the timer response bit positions.
    localparam logic [1:0] STEP_FILL  = 2'd0;
    localparam logic [1:0] STEP_WASH  = 2'd1;
    localparam logic [1:0] STEP_RINSE = 2'd2;
    localparam logic [1:0] STEP_SPIN  = 2'd3;

    // Program selector codes.
    localparam logic [1:0] PROG_QUICK  = 2'b00;
    localparam logic [1:0] PROG_NORMAL = 2'b01;
    localparam logic [1:0] PROG_HEAVY  = 2'b10;
    localparam logic [1:0] PROG_RSPIN  = 2'b11;

    // Motor speed codes.
    localparam logic [1:0] MOT_OFF  = 2'b00;
    localparam logic [1:0] MOT_SLOW = 2'b01;
    localparam logic [1:0] MOT_FAST = 2'b10;

    // 16-bit add that clamps at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/wash_duration_lut.sv
// Combinational map from (program, step) to the step duration in timer ticks.
// Ports:
//   prog     - latched program code
//   step     - current step index
//   duration - tick count for that step (quick halves with a floor of 1,
//              heavy extends WASH/RINSE with saturation, others use base)
module wash_duration_lut
    import wash_pkg::*;
#(
    parameter logic [15:0] FILL_T      = 16'd10,
    parameter logic [15:0] WASH_T      = 16'd30,
    parameter logic [15:0] RINSE_T     = 16'd20,
    parameter logic [15:0] SPIN_T      = 16'd15,
    parameter logic [15:0] HEAVY_EXTRA = 16'd10
) (
    input  logic [1:0]  prog,
    input  logic [1:0]  step,
    output logic [15:0] duration
);

    logic [15:0] base_s;
    logic [15:0] half_s;

    // Pick the base time for the step, then adjust it for the program.
    always_comb begin
        base_s = FILL_T;
        case (step)
            STEP_FILL:  base_s = FILL_T;
            STEP_WASH:  base_s = WASH_T;
            STEP_RINSE: base_s = RINSE_T;
            STEP_SPIN:  base_s = SPIN_T;
            default:    base_s = FILL_T;
        endcase

        half_s   = base_s >> 1;
        duration = base_s;
        case (prog)
            PROG_QUICK: begin
                // A zero duration would never let the timer respond.
                if (half_s == 16'd0) begin
                    duration = 16'd1;
                end else begin
                    duration = half_s;
                end
            end
            PROG_HEAVY: begin
                if ((step == STEP_WASH) || (step == STEP_RINSE)) begin
                    duration = sat_add16(base_s, HEAVY_EXTRA);
                end else begin
                    duration = base_s;
                end
            end
            default: duration = base_s;
        endcase
    end

endmodule

// File: rtl/wash_sequencer.sv
// Top-level washing-machine cycle controller. Steps the shared timer
// through FILL, WASH, RINSE and SPIN, drives valve and motor, and handles
// lid pause, abort and a per-step watchdog.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_start         - pulse, begins a cycle from IDLE or DONE
//   i_pause         - level, lid open
//   i_abort         - pulse, cancel cycle / clear fault
//   i_prog          - program select
//   i_tmr_resp      - per-step timer response bits
//   o_tmr_start     - timer enable (low clears the timer)
//   o_tmr_step      - timer step index
//   o_tmr_duration  - tick count for the current step (combinational)
//   o_state         - FSM state code
//   o_busy/o_done/o_fault - status
//   o_valve/o_motor - actuators
module wash_sequencer
    import wash_pkg::*;
#(
    parameter logic [15:0]       FILL_T      = 16'd10,
    parameter logic [15:0]       WASH_T      = 16'd30,
    parameter logic [15:0]       RINSE_T     = 16'd20,
    parameter logic [15:0]       SPIN_T      = 16'd15,
    parameter logic [15:0]       HEAVY_EXTRA = 16'd10,
    parameter int                WDOG_W      = 28,
    parameter logic [WDOG_W-1:0] WDOG_MAX    = 28'd200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_abort,
    input  logic [1:0]  i_prog,
    input  logic [3:0]  i_tmr_resp,
    output logic        o_tmr_start,
    output logic [1:0]  o_tmr_step,
    output logic [15:0] o_tmr_duration,
    output logic [2:0]  o_state,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic        o_valve,
    output logic [1:0]  o_motor
);

    localparam logic [WDOG_W-1:0] WDOG_ZERO = {WDOG_W{1'b0}};
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};
    // The increment made on this RUN cycle is the one that reaches WDOG_MAX.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - WDOG_ONE;

    state_e             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [1:0]         prog_q, prog_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [3:0]         resp_prev_q;
    logic               step_edge_s;

    logic               tmr_start_q, tmr_start_d;
    logic [1:0]         tmr_step_q, tmr_step_d;
    logic [2:0]         state_out_q, state_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic               valve_q, valve_d;
    logic [1:0]         motor_q, motor_d;

    wash_duration_lut #(
        .FILL_T      (FILL_T),
        .WASH_T      (WASH_T),
        .RINSE_T     (RINSE_T),
        .SPIN_T      (SPIN_T),
        .HEAVY_EXTRA (HEAVY_EXTRA)
    ) u_lut (
        .prog     (prog_q),
        .step     (step_q),
        .duration (o_tmr_duration)
    );

    // Next-state, step, program and watchdog logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        prog_d  = prog_q;
        wdog_d  = wdog_q;
        // Only the current step's bit may complete it; other bits are ignored.
        step_edge_s = i_tmr_resp[step_q] & ~resp_prev_q[step_q];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                wdog_d = WDOG_ZERO;
                if (i_abort && (state_q == ST_DONE)) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_FILL;
                end else if (i_start) begin
                    prog_d  = i_prog;
                    step_d  = (i_prog == PROG_RSPIN) ? STEP_RINSE : STEP_FILL;
                    state_d = ST_GAP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                wdog_d = WDOG_ZERO;
                if (i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_FILL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + WDOG_ONE;
                if (i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_FILL;
                    wdog_d  = WDOG_ZERO;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_FAULT;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (step_edge_s) begin
                    if (step_q == STEP_SPIN) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_FILL;
                    wdog_d  = WDOG_ZERO;
                end else if (!i_pause) begin
                    // Resume through GAP so the timer restarts the step from zero.
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_FAULT: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_FILL;
                    wdog_d  = WDOG_ZERO;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = STEP_FILL;
                wdog_d  = WDOG_ZERO;
            end
        endcase
    end

    // Output values derived from the next state so the registered outputs
    // line up with the state register.
    always_comb begin
        state_out_d = state_d;
        tmr_step_d  = step_d;
        tmr_start_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_GAP) || (state_d == ST_PAUSE);
        done_d      = (state_d == ST_DONE) && (state_q != ST_DONE);
        fault_d     = (state_d == ST_FAULT);
        valve_d     = 1'b0;
        motor_d     = MOT_OFF;
        if (state_d == ST_RUN) begin
            case (step_d)
                STEP_FILL:  begin valve_d = 1'b1; motor_d = MOT_OFF;  end
                STEP_WASH:  begin valve_d = 1'b0; motor_d = MOT_SLOW; end
                STEP_RINSE: begin valve_d = 1'b1; motor_d = MOT_SLOW; end
                STEP_SPIN:  begin valve_d = 1'b0; motor_d = MOT_FAST; end
                default:    begin valve_d = 1'b0; motor_d = MOT_OFF;  end
            endcase
        end else begin
            valve_d = 1'b0;
            motor_d = MOT_OFF;
        end
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_FILL;
            prog_q      <= PROG_NORMAL;
            wdog_q      <= WDOG_ZERO;
            resp_prev_q <= 4'b0000;
            tmr_start_q <= 1'b0;
            tmr_step_q  <= 2'd0;
            state_out_q <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            valve_q     <= 1'b0;
            motor_q     <= MOT_OFF;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            prog_q      <= prog_d;
            wdog_q      <= wdog_d;
            resp_prev_q <= i_tmr_resp;
            tmr_start_q <= tmr_start_d;
            tmr_step_q  <= tmr_step_d;
            state_out_q <= state_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            valve_q     <= valve_d;
            motor_q     <= motor_d;
        end
    end

    assign o_tmr_start = tmr_start_q;
    assign o_tmr_step  = tmr_step_q;
    assign o_state     = state_out_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_fault     = fault_q;
    assign o_valve     = valve_q;
    assign o_motor     = motor_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: program table, randomized
// programs against a step-level reference model, and hand-written
// sequences for pause, wrong-step response, watchdog, abort and reset.
module tb_wash_sequencer;

    logic        clk = 1'b0;
    logic        rst, i_start, i_pause, i_abort;
    logic [1:0]  i_prog;
    logic [3:0]  i_tmr_resp;
    logic        o_tmr_start;
    logic [1:0]  o_tmr_step;
    logic [15:0] o_tmr_duration;
    logic [2:0]  o_state;
    logic        o_busy, o_done, o_fault, o_valve;
    logic [1:0]  o_motor;

    always #5 clk = ~clk;

    wash_sequencer #(.WDOG_MAX(28'd100)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause),
        .i_abort(i_abort), .i_prog(i_prog), .i_tmr_resp(i_tmr_resp),
        .o_tmr_start(o_tmr_start), .o_tmr_step(o_tmr_step),
        .o_tmr_duration(o_tmr_duration), .o_state(o_state), .o_busy(o_busy),
        .o_done(o_done), .o_fault(o_fault), .o_valve(o_valve), .o_motor(o_motor)
    );

    typedef struct packed {
        logic [1:0]       prog;
        logic [1:0]       first;
        logic [3:0][15:0] dur;
    } vec_t;

    vec_t tbl [4];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tcnt    = 0;
    logic [3:0] tresp  = 4'b0000;
    logic [3:0] inject = 4'b0000;
    bit   tmr_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; then update the behavioural step timer from the outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!o_tmr_start) begin
            tcnt  = 0;
            tresp = 4'b0000;
        end else begin
            tcnt++;
            if (tmr_en && (tcnt >= int'(o_tmr_duration))) tresp[o_tmr_step] = 1'b1;
        end
        i_tmr_resp = tresp | inject;
    endtask

    // Reference: step durations from the program rules.
    function automatic int model_dur(input int prog, input int step);
        int base [4];
        int d;
        base = '{10, 30, 20, 15};
        d = base[step];
        if (prog == 0) begin
            d = (d / 2 < 1) ? 1 : d / 2;
        end else if (prog == 2 && (step == 1 || step == 2)) begin
            d = d + 10;
            if (d > 65535) d = 65535;
        end
        return d;
    endfunction

    function automatic int model_valve(input int step);
        return (step == 0 || step == 2) ? 1 : 0;
    endfunction

    function automatic int model_motor(input int step);
        return (step == 0) ? 0 : ((step == 3) ? 2 : 1);
    endfunction

    // Expects the current sample to be the GAP before step k; runs the step.
    task automatic run_one_step(input int k, input int exp_dur, input string tag);
        int n;
        check({tag, "_gap_state"}, o_state, 2);
        check({tag, "_gap_start"}, o_tmr_start, 0);
        check({tag, "_gap_step"}, o_tmr_step, k);
        tick();
        check({tag, "_run_state"}, o_state, 1);
        check({tag, "_run_step"}, o_tmr_step, k);
        check({tag, "_dur"}, o_tmr_duration, exp_dur);
        check({tag, "_start"}, o_tmr_start, 1);
        check({tag, "_valve"}, o_valve, model_valve(k));
        check({tag, "_motor"}, o_motor, model_motor(k));
        check({tag, "_busy"}, o_busy, 1);
        n = 0;
        while (o_state == 3'd1 && n < 500) begin
            n++;
            tick();
        end
        check({tag, "_run_len"}, n, exp_dur);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done_state"}, o_state, 4);
        check({tag, "_done_pulse"}, o_done, 1);
        check({tag, "_done_busy"}, o_busy, 0);
        tick();
        check({tag, "_done_once"}, o_done, 0);
        check({tag, "_done_hold"}, o_state, 4);
    endtask

    task automatic run_program(input logic [1:0] p, input int first,
                               input logic [3:0][15:0] durs, input string tag);
        i_prog  = p;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = first; k < 4; k++) begin
            run_one_step(k, int'(durs[k]), $sformatf("%s_s%0d", tag, k));
        end
        check_done(tag);
    endtask

    initial begin
        int n;
        int bad;
        int p;
        logic [3:0][15:0] md;

        tbl[0] = '{prog: 2'b01, first: 2'd0, dur: {16'd15, 16'd20, 16'd30, 16'd10}};
        tbl[1] = '{prog: 2'b10, first: 2'd0, dur: {16'd15, 16'd30, 16'd40, 16'd10}};
        tbl[2] = '{prog: 2'b11, first: 2'd2, dur: {16'd15, 16'd20, 16'd30, 16'd10}};
        tbl[3] = '{prog: 2'b00, first: 2'd0, dur: {16'd7,  16'd10, 16'd15, 16'd5}};

        rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_abort = 1'b0;
        i_prog = 2'b00; i_tmr_resp = 4'b0000;
        tick();
        tick();
        check("rst_state", o_state, 0);
        check("rst_busy", o_busy, 0);
        check("rst_start", o_tmr_start, 0);
        check("rst_step", o_tmr_step, 0);
        check("rst_actuators", {o_valve, o_motor, o_done, o_fault}, 0);
        check("rst_dur_normal", o_tmr_duration, 10);
        rst = 1'b0;
        tick();

        // Program table.
        for (int i = 0; i < 4; i++) begin
            run_program(tbl[i].prog, int'(tbl[i].first), tbl[i].dur, $sformatf("tbl%0d", i));
        end

        // Abort from DONE.
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check("abort_done_state", o_state, 0);

        // Pause mid-WASH, long enough that a non-holding watchdog would trip.
        i_prog = 2'b01; i_start = 1'b1; tick(); i_start = 1'b0;
        run_one_step(0, 10, "p_fill");
        tick();
        repeat (10) tick();
        i_pause = 1'b1;
        tick();
        check("pause_state", o_state, 3);
        check("pause_start", o_tmr_start, 0);
        check("pause_motor", o_motor, 0);
        check("pause_valve", o_valve, 0);
        check("pause_step", o_tmr_step, 1);
        check("pause_busy", o_busy, 1);
        bad = 0;
        repeat (120) begin
            tick();
            if (o_state != 3'd3 || o_tmr_step != 2'd1 || o_tmr_start || o_fault) bad++;
        end
        check("pause_hold", bad, 0);
        i_pause = 1'b0;
        tick();
        run_one_step(1, 30, "p_wash");
        run_one_step(2, 20, "p_rinse");
        run_one_step(3, 15, "p_spin");
        check_done("p");

        // Wrong-step response during WASH.
        i_start = 1'b1; tick(); i_start = 1'b0;
        run_one_step(0, 10, "w_fill");
        tmr_en = 1'b0;
        tick();
        inject = 4'b1000; i_tmr_resp = tresp | inject;
        tick();
        tick();
        inject = 4'b0000; i_tmr_resp = tresp | inject;
        repeat (3) tick();
        check("wrong_bit_state", o_state, 1);
        check("wrong_bit_step", o_tmr_step, 1);
        inject = 4'b0010; i_tmr_resp = tresp | inject;
        tick();
        check("right_bit_state", o_state, 2);
        check("right_bit_step", o_tmr_step, 2);
        inject = 4'b0000; tmr_en = 1'b1; i_tmr_resp = tresp | inject;
        run_one_step(2, 20, "w_rinse");
        run_one_step(3, 15, "w_spin");
        check_done("w");

        // Watchdog: no responses at all.
        tmr_en = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick();
        n = 0;
        while (o_state == 3'd1 && n < 300) begin
            n++;
            tick();
        end
        check("wdog_run_cycles", n, 100);
        check("wdog_state", o_state, 5);
        check("wdog_fault", o_fault, 1);
        check("wdog_outputs", {o_tmr_start, o_valve, o_motor, o_busy}, 0);
        i_start = 1'b1; tick(); i_start = 1'b0;
        check("wdog_start_ignored", o_state, 5);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check("wdog_abort_state", o_state, 0);
        check("wdog_abort_fault", o_fault, 0);
        check("wdog_abort_step", o_tmr_step, 0);
        tmr_en = 1'b1;

        // Abort and pause in the same cycle.
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick();
        repeat (3) tick();
        i_abort = 1'b1; i_pause = 1'b1; tick(); i_abort = 1'b0; i_pause = 1'b0;
        check("abort_pause_state", o_state, 0);
        check("abort_pause_outputs", {o_tmr_step, o_busy, o_tmr_start, o_valve, o_motor}, 0);

        // Start while busy is ignored, including the program change.
        i_prog = 2'b01; i_start = 1'b1; tick(); i_start = 1'b0;
        tick();
        repeat (2) tick();
        i_prog = 2'b10; i_start = 1'b1; tick(); i_start = 1'b0;
        check("busy_start_state", o_state, 1);
        check("busy_start_step", o_tmr_step, 0);
        n = 0;
        while (o_state == 3'd1 && n < 300) begin
            n++;
            tick();
        end
        run_one_step(1, 30, "busy_wash");
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        check("busy_abort_state", o_state, 0);

        // Reset mid-RINSE.
        i_prog = 2'b11; i_start = 1'b1; tick(); i_start = 1'b0;
        tick();
        check("rr_step", o_tmr_step, 2);
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rr_state", o_state, 0);
        check("rr_outputs", {o_tmr_step, o_busy, o_tmr_start, o_valve, o_motor, o_done, o_fault}, 0);
        check("rr_prog_reset", o_tmr_duration, 10);
        tick();

        // Randomized programs against the reference model.
        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) md[k] = 16'(model_dur(p, k));
            run_program(2'(p), (p == 3) ? 2 : 0, md, $sformatf("rnd%0d_p%0d", r, p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
